// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: register offsets, CON bit positions and FSM states for the UART transmit responder
package uart_tx_pkg;
  localparam logic [7:0] TXD_OFF = 8'h18;
  localparam logic [7:0] CON_OFF = 8'h20;
  localparam int CON_IRQ_EN = 0;
  localparam int CON_TX_DONE = 1;
  localparam int CON_FULL = 2;
  localparam int CON_BUSY = 3;
  localparam int CON_EMPTY = 4;
  localparam int CON_OVF = 5;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with occupancy count, depth a power of two
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign dout = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/uart_tx_responder.sv
// uart_tx_responder: memory-mapped 8N1 UART transmitter with FIFO, sticky flags and interrupt
module uart_tx_responder import uart_tx_pkg::*; #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        UART_TX,
  output logic        irqout
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, dout;
  logic tx, tx_n, tx_done, ovf, irq_en;
  logic pop, push, full, empty, bit_end, done_set, wr_txd, wr_con;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [5:0] con;
  logic unused_bits;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(wdata[7:0]),
    .dout(dout), .full(full), .empty(empty), .count(fifo_count)
  );
  assign unused_bits = ^{addr[31:8], wdata[31:8], fifo_count};
  assign wr_txd = wr && addr[7:0] == TXD_OFF;
  assign wr_con = wr && addr[7:0] == CON_OFF;
  assign push = wr_txd && (!full || pop);
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
    idx_n = idx;
    shift_n = shift;
    tx_n = tx;
    pop = 1'b0;
    done_set = 1'b0;
    case (state)
      IDLE: begin
        tx_n = empty;
        pop = !empty;
        shift_n = empty ? shift : dout;
        state_n = empty ? IDLE : START;
      end
      START: if (bit_end) begin
        state_n = DATA;
        tx_n = shift[0];
        idx_n = '0;
      end
      DATA: if (bit_end) begin
        shift_n = shift >> 1;
        idx_n = idx + 3'd1;
        tx_n = idx == 3'd7 ? 1'b1 : shift[1];
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        done_set = 1'b1;
        pop = !empty;
        shift_n = empty ? shift : dout;
        tx_n = empty;
        state_n = empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      tx_done <= 1'b0;
      ovf <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      tx <= tx_n;
      tx_done <= done_set || (tx_done && !(wr_con && wdata[CON_TX_DONE]));
      ovf <= (wr_txd && !push) || (ovf && !(wr_con && wdata[CON_OVF]));
      irq_en <= wr_con ? wdata[CON_IRQ_EN] : irq_en;
    end
  end
  always_comb begin
    con = '0;
    con[CON_IRQ_EN] = irq_en;
    con[CON_TX_DONE] = tx_done;
    con[CON_FULL] = full;
    con[CON_BUSY] = state != IDLE;
    con[CON_EMPTY] = empty;
    con[CON_OVF] = ovf;
  end
  assign rdata = (rd && addr[7:0] == CON_OFF) ? {26'd0, con} : 32'd0;
  assign UART_TX = tx;
  assign irqout = irq_en & tx_done;
endmodule

// File: tb/tb_uart_tx_responder.sv
// tb_uart_tx_responder: directed bench with a frame-decoding scoreboard for uart_tx_responder
module tb_uart_tx_responder;
  logic clk = 1'b0, reset = 1'b1, rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic UART_TX, irqout;
  int checks = 0, fails = 0, starts = 0;
  bit mon_en = 1'b1;
  logic [7:0] sb[$];
  uart_tx_responder #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .UART_TX(UART_TX), .irqout(irqout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr_bus(input logic [7:0] a, input logic [31:0] d);
    wr = 1'b1;
    addr = {24'd0, a};
    wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input bit expect_frame);
    if (expect_frame) sb.push_back(b);
    wr_bus(8'h18, {24'hABCDEF, b});
  endtask
  task automatic rd_bus(input logic [7:0] a, output logic [31:0] v);
    rd = 1'b1;
    addr = {24'h000040, a};
    #1 v = rdata;
    rd = 1'b0;
  endtask
  always begin
    logic [7:0] rx;
    bit en;
    @(negedge clk);
    if (UART_TX === 1'b0) begin
      starts++;
      en = mon_en;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        rx[i] = UART_TX;
        repeat (4) @(negedge clk);
      end
      if (en && mon_en) begin
        check("stop_bit", {31'd0, UART_TX}, 32'd1);
        check("frame_expected", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) check("frame_byte", {24'd0, rx}, {24'd0, sb.pop_front()});
      end
      repeat (2) @(negedge clk);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] v;
    int k, snap, lows;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_tx", {31'd0, UART_TX}, 32'd1);
    check("rst_irq", {31'd0, irqout}, 32'd0);
    rd_bus(8'h20, v); check("rst_con", v, 32'h10);
    rd_bus(8'h18, v); check("rd_txd", v, 32'h0);
    rd_bus(8'h24, v); check("rd_unmapped", v, 32'h0);
    addr = 32'h20; #1 check("rd_low", rdata, 32'h0);
    @(negedge clk);
    wr_bus(8'h1C, 32'h23);
    repeat (3) @(negedge clk);
    rd_bus(8'h20, v); check("wr_unmapped_con", v, 32'h10);
    check("wr_unmapped_tx", {31'd0, UART_TX}, 32'd1);
    send(8'h55, 1'b1);
    check("pre_start", {31'd0, UART_TX}, 32'd1);
    @(negedge clk); check("start_low", {31'd0, UART_TX}, 32'd0);
    repeat (3) @(negedge clk); check("start_end", {31'd0, UART_TX}, 32'd0);
    @(negedge clk); check("bit0", {31'd0, UART_TX}, 32'd1);
    repeat (4) @(negedge clk); check("bit1", {31'd0, UART_TX}, 32'd0);
    repeat (31) @(negedge clk);
    rd_bus(8'h20, v); check("con_pre_done", v, 32'h18);
    @(negedge clk);
    rd_bus(8'h20, v); check("con_done", v, 32'h12);
    wr_bus(8'h20, 32'h02);
    rd_bus(8'h20, v); check("done_cleared", v, 32'h10);
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    k = 0;
    for (int i = 0; i < 80; i++) begin
      rd_bus(8'h20, v);
      k += v[3];
      if (i == 39) check("b2b_stop", {31'd0, UART_TX}, 32'd1);
      if (i == 40) check("b2b_start", {31'd0, UART_TX}, 32'd0);
      @(negedge clk);
    end
    check("busy_80", k, 80);
    rd_bus(8'h20, v); check("busy_end", v, 32'h12);
    wr_bus(8'h20, 32'h02);
    for (int i = 0; i < 6; i++) send(8'h11 * i + 8'h07, i < 5);
    rd_bus(8'h20, v); check("ovf_con", v, 32'h2C);
    wr_bus(8'h20, 32'h20);
    rd_bus(8'h20, v); check("ovf_clear", v, 32'h0C);
    k = 0;
    rd_bus(8'h20, v);
    while ((v[3] || !v[4]) && k < 400) begin
      @(negedge clk);
      rd_bus(8'h20, v);
      k++;
    end
    check("drain_con", v, 32'h12);
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    wr_bus(8'h20, 32'h03);
    check("irq_en_only", {31'd0, irqout}, 32'd0);
    send(8'h81, 1'b1);
    k = 0;
    while (!irqout && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("irq_latency", k, 41);
    rd_bus(8'h20, v); check("irq_con", v, 32'h13);
    wr_bus(8'h20, 32'h03);
    check("irq_clear", {31'd0, irqout}, 32'd0);
    send(8'hC3, 1'b1);
    repeat (40) @(negedge clk);
    check("irq_pre_set", {31'd0, irqout}, 32'd0);
    wr_bus(8'h20, 32'h03);
    check("irq_set_wins", {31'd0, irqout}, 32'd1);
    wr_bus(8'h20, 32'h02);
    check("irq_off", {31'd0, irqout}, 32'd0);
    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    send(8'h0F, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h99, 1'b0);
    repeat (16) @(negedge clk);
    rd_bus(8'h20, v); check("pre_rst_busy", v, 32'h08);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_tx", {31'd0, UART_TX}, 32'd1);
    check("midrst_irq", {31'd0, irqout}, 32'd0);
    rd_bus(8'h20, v); check("midrst_con", v, 32'h10);
    snap = starts;
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      lows += (UART_TX !== 1'b1);
    end
    check("no_resume_line", lows, 0);
    check("no_resume_frames", starts, snap);
    check("sb_final", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
